// File: rtl/multicycle_control_unit.sv
// Multi-cycle ARM-subset control unit.
// A Moore FSM sequences each instruction over 3-5 cycles so one ALU and one
// unified memory are shared. The architectural NZCV flags are held here and
// all condition codes are evaluated against them in DECODE.
//
// state  | meaning
// FETCH  | IR <- mem[PC], PC <- PC+4
// DECODE | read registers, evaluate condition, pick instruction class
// MEMADR | ALUOut <- Rn +/- imm12
// MEMRD  | read memory at ALUOut
// MEMWB  | Rd <- ReadData
// MEMWR  | mem[ALUOut] <- Rd
// EXECR  | ALU on register operand, optional flag update
// EXECI  | ALU on imm8 operand, optional flag update
// ALUWB  | Rd <- ALUOut
// BRANCH | PC <- PC+8 + imm24<<2
// LINK   | R14 <- PC (instruction+4)
module multicycle_control_unit #(
    parameter bit ENABLE_LOGIC = 1'b1,
    parameter bit ENABLE_BL    = 1'b1,
    parameter int ALUCTRL_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          Instr,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 WA3Link,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [3:0]           Flags,
    output logic [3:0]           State,
    output logic                 IllegalInstr
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_LINK   = 4'd10
    } state_t;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(2'd0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(2'd1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2'd2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(2'd3);

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    logic [3:0] cond, cmd;
    logic [1:0] op;
    logic       ibit, sbit, ubit, lbit_mem, lbit_br;
    logic       fn, fz, fc, fv;
    logic       cond_pass, dp_legal, illegal, is_cmp, logic_op;
    logic [ALUCTRL_W-1:0] dp_alu;
    logic       pc_write, mem_write, ir_write, reg_write;
    logic       unused_bits;

    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign ibit     = Instr[25];
    assign cmd      = Instr[24:21];
    assign sbit     = Instr[20];
    assign ubit     = Instr[23];
    assign lbit_mem = Instr[20];
    assign lbit_br  = Instr[24];
    assign unused_bits = ^Instr[19:0];

    assign {fn, fz, fc, fv} = flags_q;

    // Condition check against the flags as they stood before this instruction
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = fz;
            4'b0001: cond_pass = !fz;
            4'b0010: cond_pass = fc;
            4'b0011: cond_pass = !fc;
            4'b0100: cond_pass = fn;
            4'b0101: cond_pass = !fn;
            4'b0110: cond_pass = fv;
            4'b0111: cond_pass = !fv;
            4'b1000: cond_pass = fc & !fz;
            4'b1001: cond_pass = !fc | fz;
            4'b1010: cond_pass = (fn == fv);
            4'b1011: cond_pass = (fn != fv);
            4'b1100: cond_pass = !fz & (fn == fv);
            4'b1101: cond_pass = fz | (fn != fv);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Data-processing opcode decode; MOV rides on ORR with Rn forced to 0
    always_comb begin
        dp_legal = 1'b0;
        dp_alu   = ALU_ADD;
        case (cmd)
            4'b0100: begin dp_legal = 1'b1;         dp_alu = ALU_ADD; end
            4'b0010: begin dp_legal = 1'b1;         dp_alu = ALU_SUB; end
            4'b1010: begin dp_legal = sbit;         dp_alu = ALU_SUB; end
            4'b1101: begin dp_legal = 1'b1;         dp_alu = ALU_ORR; end
            4'b0000: begin dp_legal = ENABLE_LOGIC; dp_alu = ALU_AND; end
            4'b1100: begin dp_legal = ENABLE_LOGIC; dp_alu = ALU_ORR; end
            default: begin dp_legal = 1'b0;         dp_alu = ALU_ADD; end
        endcase
    end

    assign is_cmp   = (cmd == 4'b1010);
    assign logic_op = (cmd == 4'b0000) || (cmd == 4'b1100) || (cmd == 4'b1101);
    assign illegal  = (op == 2'b11) || ((op == 2'b00) && !dp_legal);

    // Next state and flag update
    always_comb begin
        state_d = S_FETCH;
        flags_d = flags_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!cond_pass || illegal) state_d = S_FETCH;
                else begin
                    case (op)
                        2'b01:   state_d = S_MEMADR;
                        2'b00:   state_d = ibit ? S_EXECI : S_EXECR;
                        2'b10:   state_d = (lbit_br && ENABLE_BL) ? S_LINK : S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = lbit_mem ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR, S_EXECI: begin
                state_d = is_cmp ? S_FETCH : S_ALUWB;
                if (sbit) flags_d = logic_op ? {ALUFlags[3:2], flags_q[1:0]} : ALUFlags;
            end
            S_LINK:   state_d = S_BRANCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // State and flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Moore datapath controls; ImmSrc/RegSrc follow the instruction class
    always_comb begin
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        AdrSrc     = 1'b0;
        WA3Link    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
        RegSrc     = (op == 2'b10) ? 2'b01 : ((op == 2'b01) && !lbit_mem) ? 2'b10 : 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = ubit ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR:  ALUControl = dp_alu;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp_alu;
            end
            S_ALUWB:  reg_write = 1'b1;
            S_LINK: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b11;
                ResultSrc = 2'b10;
                reg_write = 1'b1;
                WA3Link   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are gated by reset so nothing escapes while it is held
    assign PCWrite      = pc_write  & reset_n;
    assign MemWrite     = mem_write & reset_n;
    assign IRWrite      = ir_write  & reset_n;
    assign RegWrite     = reg_write & reset_n;
    assign IllegalInstr = (state_q == S_DECODE) & cond_pass & illegal & reset_n;
    assign Flags        = flags_q;
    assign State        = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: default build (dut) plus a build with logic ops and BL link
// disabled (dut2) sharing clock, reset and instruction.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;

    logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, WA3Link, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0] Flags, State;

    logic PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, WA3Link2, IllegalInstr2;
    logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2, ALUControl2, ImmSrc2, RegSrc2;
    logic [3:0] Flags2, State2;

    int vecs  = 0;
    int fails = 0;

    multicycle_control_unit dut (
        .clk(clk), .reset_n(reset_n), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .WA3Link(WA3Link), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags), .State(State),
        .IllegalInstr(IllegalInstr)
    );

    multicycle_control_unit #(.ENABLE_LOGIC(1'b0), .ENABLE_BL(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
        .RegWrite(RegWrite2), .WA3Link(WA3Link2), .ResultSrc(ResultSrc2),
        .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUControl(ALUControl2),
        .ImmSrc(ImmSrc2), .RegSrc(RegSrc2), .Flags(Flags2), .State(State2),
        .IllegalInstr(IllegalInstr2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        Instr    = 32'hEC000000;
        ALUFlags = 4'b0000;
        step();
        step();
        chk("rst_state", State, 4'd0);
        chk("rst_flags", Flags, 4'b0000);
        chk("rst_wr", {PCWrite, IRWrite, RegWrite, MemWrite, IllegalInstr}, 5'b0);
        reset_n = 1'b1;
        #1;
        chk("rel_fetch", {IRWrite, PCWrite}, 2'b11);

        // ADD R0,R1,R2
        Instr = 32'hE0810002;
        step(); chk("add_s1", State, 4'd1); chk("add_rw1", RegWrite, 1'b0);
        step(); chk("add_s6", State, 4'd6); chk("add_alu", ALUControl, 2'd0);
        chk("add_rw6", RegWrite, 1'b0);
        step(); chk("add_s8", State, 4'd8); chk("add_rw8", RegWrite, 1'b1);
        step(); chk("add_s0", State, 4'd0); chk("add_flags", Flags, 4'b0000);

        // SUBS immediate, ALU reports Z and C
        Instr = 32'hE2533001; ALUFlags = 4'b0110;
        step(); chk("subs_s1", State, 4'd1);
        step(); chk("subs_s7", State, 4'd7); chk("subs_alu", ALUControl, 2'd1);
        chk("subs_srcb", ALUSrcB, 2'b01);
        step(); chk("subs_s8", State, 4'd8); chk("subs_flags", Flags, 4'b0110);
        step(); chk("subs_s0", State, 4'd0);
        ALUFlags = 4'b0000;

        // BEQ taken (Z=1)
        Instr = 32'h0A000002;
        step(); chk("beq_s1", State, 4'd1);
        step(); chk("beq_s9", State, 4'd9); chk("beq_pcw", PCWrite, 1'b1);
        chk("beq_regsrc", RegSrc, 2'b01);
        step(); chk("beq_s0", State, 4'd0);

        // BNE not taken
        Instr = 32'h1A000002;
        step(); chk("bne_s1", State, 4'd1); chk("bne_pcw", PCWrite, 1'b0);
        step(); chk("bne_s0", State, 4'd0);

        // LDR
        Instr = 32'hE5901004;
        step(); chk("ldr_s1", State, 4'd1);
        step(); chk("ldr_s2", State, 4'd2); chk("ldr_alu", ALUControl, 2'd0);
        step(); chk("ldr_s3", State, 4'd3); chk("ldr_adr", AdrSrc, 1'b1);
        step(); chk("ldr_s4", State, 4'd4);
        chk("ldr_wb", {ResultSrc, RegWrite}, 3'b011);
        step(); chk("ldr_s0", State, 4'd0);

        // STR with U=0
        Instr = 32'hE5001004;
        step(); chk("str_s1", State, 4'd1);
        step(); chk("str_s2", State, 4'd2); chk("str_alu", ALUControl, 2'd1);
        chk("str_mw2", MemWrite, 1'b0);
        step(); chk("str_s5", State, 4'd5); chk("str_mw5", MemWrite, 1'b1);
        chk("str_regsrc1", RegSrc[1], 1'b1); chk("str_rw", RegWrite, 1'b0);
        step(); chk("str_s0", State, 4'd0); chk("str_flags", Flags, 4'b0110);

        // BL: link in default build, plain branch in dut2
        Instr = 32'hEB000010;
        step(); chk("bl_s1", State, 4'd1);
        step(); chk("bl_s10", State, 4'd10);
        chk("bl_link", {WA3Link, RegWrite}, 2'b11);
        chk("bl2_s9", State2, 4'd9); chk("bl2_rw", RegWrite2, 1'b0);
        chk("bl2_pcw", PCWrite2, 1'b1);
        step(); chk("bl_s9", State, 4'd9); chk("bl_pcw", PCWrite, 1'b1);
        chk("bl2_s0", State2, 4'd0);
        step(); chk("bl_s0", State, 4'd0);
        reset_pulse();

        // Cond=1111 never executes and is not reported illegal
        Instr = 32'hF0810002;
        step(); chk("nv_s1", State, 4'd1); chk("nv_ill", IllegalInstr, 1'b0);
        step(); chk("nv_s0", State, 4'd0);

        // Unsupported opcode 0001 (illegal in both builds)
        Instr = 32'hE0200002;
        step(); chk("eor_ill", IllegalInstr, 1'b1); chk("eor2_ill", IllegalInstr2, 1'b1);
        chk("eor_wr", {PCWrite, RegWrite, MemWrite, IRWrite}, 4'b0);
        step(); chk("eor_s0", State, 4'd0); chk("eor2_s0", State2, 4'd0);

        // CMP immediate loads all flags and skips writeback
        Instr = 32'hE3500000; ALUFlags = 4'b0011;
        step(); chk("cmp_s1", State, 4'd1);
        step(); chk("cmp_s7", State, 4'd7); chk("cmp_alu", ALUControl, 2'd1);
        step(); chk("cmp_s0", State, 4'd0); chk("cmp_flags", Flags, 4'b0011);
        chk("cmp2_flags", Flags2, 4'b0011);

        // ANDS: N,Z load, C,V kept; illegal when logic ops disabled
        Instr = 32'hE0100002; ALUFlags = 4'b1000;
        step(); chk("ands_ill", IllegalInstr, 1'b0); chk("ands2_ill", IllegalInstr2, 1'b1);
        step(); chk("ands_s6", State, 4'd6); chk("ands_alu", ALUControl, 2'd2);
        chk("ands2_s0", State2, 4'd0);
        step(); chk("ands_s8", State, 4'd8); chk("ands_flags", Flags, 4'b1011);
        chk("ands2_flags", Flags2, 4'b0011);
        step(); chk("ands_s0", State, 4'd0);
        ALUFlags = 4'b0000;
        reset_pulse();

        // Reset during MEMRD aborts the load
        Instr = 32'hE5901004;
        step(); step(); step();
        chk("abort_s3", State, 4'd3);
        reset_n = 1'b0;
        #1;
        chk("abort_s0", State, 4'd0); chk("abort_rw", RegWrite, 1'b0);
        chk("abort_flags", Flags, 4'b0000);
        step(); chk("abort_hold", {State, RegWrite}, 5'd0);
        reset_n = 1'b1;
        step(); chk("abort_s1", State, 4'd1); chk("abort_rw2", RegWrite, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
